// File: rtl/xtile_load_sched_if.sv
// Row-loader handshake between the tile scheduler and the X-tile row loader.
// The scheduler is the master: it issues rows and acknowledges loaded rows.
interface xtile_load_sched_if #(
    parameter int K_W = 10
);
    logic           start_k;
    logic [K_W-1:0] k_idx;
    logic           row_valid;
    logic           row_accept;

    modport master (
        output start_k,
        output k_idx,
        output row_accept,
        input  row_valid
    );

    modport slave (
        input  start_k,
        input  k_idx,
        input  row_accept,
        output row_valid
    );
endinterface

// File: rtl/xtile_load_sched.sv
// Tile sequencer for the X-tile row loader, with CPU X-SRAM write-port arbitration.
// Optional WAIT_ROW/DRAIN watchdog is enabled by defining XTILE_SCHED_TIMEOUT_EN.
module xtile_load_sched #(
    parameter int KMAX = 1024,
    parameter int K_W  = (KMAX > 1) ? $clog2(KMAX) : 1
`ifdef XTILE_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tile_start,
    input  logic [K_W-1:0]      k_base,
    input  logic [K_W:0]        k_len,
    input  logic                abort,
    output logic                tile_ready,
    output logic                tile_busy,
    output logic                tile_done,
    output logic                err_range,
    output logic                err_timeout,
    output logic [K_W:0]        rows_done,
    xtile_load_sched_if.master  ld,
    input  logic                cpu_x_req,
    output logic                cpu_x_gnt
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ROW,
        ACCEPT,
        DRAIN
    } state_t;

    localparam logic [K_W+1:0] KMAX_L = (K_W+2)'(KMAX);

    state_t         state;
    logic [K_W-1:0] base_q;
    logic [K_W:0]   len_q;
    logic [K_W+1:0] end_row;

    assign end_row = {2'b00, k_base} + {1'b0, k_len};

    // The loader reads SRAM only between start_k and row_accept.
    assign cpu_x_gnt = cpu_x_req &
                       ((state == IDLE) |
                        (state == ISSUE) |
                        (state == ACCEPT));

`ifdef XTILE_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] wd_cnt;
    logic          err_to_q;
    logic          wd_fire;

    assign wd_fire     = (wd_cnt == WD_LAST);
    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            rows_done     <= '0;
            tile_ready    <= 1'b1;
            tile_busy     <= 1'b0;
            tile_done     <= 1'b0;
            err_range     <= 1'b0;
            ld.start_k    <= 1'b0;
            ld.k_idx      <= '0;
            ld.row_accept <= 1'b0;
`ifdef XTILE_SCHED_TIMEOUT_EN
            wd_cnt        <= '0;
            err_to_q      <= 1'b0;
`endif
        end else begin
            tile_done     <= 1'b0;
            err_range     <= 1'b0;
            ld.start_k    <= 1'b0;
            ld.row_accept <= 1'b0;
`ifdef XTILE_SCHED_TIMEOUT_EN
            err_to_q      <= 1'b0;
            wd_cnt        <= wd_cnt + 1'b1;
`endif
            unique case (state)
                IDLE: begin
                    if (tile_start) begin
                        if (end_row > KMAX_L) begin
                            err_range <= 1'b1;
                        end else if (k_len == '0) begin
                            tile_done <= 1'b1;
                            rows_done <= '0;
                        end else begin
                            base_q     <= k_base;
                            len_q      <= k_len;
                            rows_done  <= '0;
                            state      <= ISSUE;
                            tile_ready <= 1'b0;
                            tile_busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        state      <= IDLE;
                        tile_ready <= 1'b1;
                        tile_busy  <= 1'b0;
                    end else if (!cpu_x_req) begin
                        ld.start_k <= 1'b1;
                        ld.k_idx   <= base_q + rows_done[K_W-1:0];
                        state      <= WAIT_ROW;
`ifdef XTILE_SCHED_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                WAIT_ROW: begin
                    if (abort) begin
                        state <= DRAIN;
`ifdef XTILE_SCHED_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end else if (ld.row_valid) begin
                        ld.row_accept <= 1'b1;
                        rows_done     <= rows_done + 1'b1;
                        state         <= ACCEPT;
`ifdef XTILE_SCHED_TIMEOUT_EN
                    end else if (wd_fire) begin
                        err_to_q   <= 1'b1;
                        state      <= IDLE;
                        tile_ready <= 1'b1;
                        tile_busy  <= 1'b0;
`endif
                    end
                end
                ACCEPT: begin
                    if (abort) begin
                        state      <= IDLE;
                        tile_ready <= 1'b1;
                        tile_busy  <= 1'b0;
                    end else if (rows_done == len_q) begin
                        tile_done  <= 1'b1;
                        state      <= IDLE;
                        tile_ready <= 1'b1;
                        tile_busy  <= 1'b0;
                    end else begin
                        state <= ISSUE;
                    end
                end
                DRAIN: begin
                    // Already aborting: a repeated abort must not strand the loader's row.
                    if (ld.row_valid) begin
                        ld.row_accept <= 1'b1;
                        state         <= IDLE;
                        tile_ready    <= 1'b1;
                        tile_busy     <= 1'b0;
`ifdef XTILE_SCHED_TIMEOUT_EN
                    end else if (wd_fire) begin
                        err_to_q   <= 1'b1;
                        state      <= IDLE;
                        tile_ready <= 1'b1;
                        tile_busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state      <= IDLE;
                    tile_ready <= 1'b1;
                    tile_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xtile_load_sched.sv
// Bench for xtile_load_sched: table of tile commands plus CPU, abort and reset sequences.
// A behavioural row loader answers start_k; a queue holds the expected k_idx stream.
module tb_xtile_load_sched;

    localparam int KMAX = 1024;
    localparam int K_W  = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tile_start = 1'b0;
    logic [K_W-1:0] k_base = '0;
    logic [K_W:0]   k_len = '0;
    logic           abort = 1'b0;
    logic           cpu_x_req = 1'b0;
    logic           tile_ready;
    logic           tile_busy;
    logic           tile_done;
    logic           err_range;
    logic           err_timeout;
    logic [K_W:0]   rows_done;
    logic           cpu_x_gnt;

    xtile_load_sched_if #(.K_W(K_W)) ld ();

    xtile_load_sched #(.KMAX(KMAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tile_start  (tile_start),
        .k_base      (k_base),
        .k_len       (k_len),
        .abort       (abort),
        .tile_ready  (tile_ready),
        .tile_busy   (tile_busy),
        .tile_done   (tile_done),
        .err_range   (err_range),
        .err_timeout (err_timeout),
        .rows_done   (rows_done),
        .ld          (ld),
        .cpu_x_req   (cpu_x_req),
        .cpu_x_gnt   (cpu_x_gnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural loader: row_valid 'lat' cycles after start_k, held until row_accept.
    int lat = 2;
    int lcnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            ld.row_valid = 1'b0;
            lcnt = 0;
        end else begin
            if (ld.row_accept) ld.row_valid = 1'b0;
            if (lcnt > 0) begin
                lcnt--;
                if (lcnt == 0) ld.row_valid = 1'b1;
            end
            if (ld.start_k) lcnt = lat;
        end
    end

    logic [K_W-1:0] exp_q[$];
    int sk_cnt, acc_cnt, done_cnt, err_cnt, to_cnt, busy_cnt;
    int sk_cyc, done_cyc, err_cyc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ld.start_k) begin
                if (sk_cnt == 0) sk_cyc = cyc;
                sk_cnt++;
                if (exp_q.size() == 0)
                    chk("start_k_unexpected", 1, 0);
                else
                    chk("k_idx", int'(ld.k_idx), int'(exp_q.pop_front()));
            end
            if (ld.row_accept) acc_cnt++;
            if (tile_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err_range) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (err_timeout) to_cnt++;
            if (tile_busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        exp_q.delete();
        sk_cnt = 0; acc_cnt = 0; done_cnt = 0; err_cnt = 0;
        to_cnt = 0; busy_cnt = 0;
        sk_cyc = 0; done_cyc = 0; err_cyc = 0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, int'(n < budget), 1);
    endtask

    typedef struct {
        int kb;
        int kl;
        bit err;
    } vec_t;

    vec_t vecs[6];
    int   model_rows = 0;

    task automatic run_vec(input vec_t v, input int idx);
        int st;
        int exp_rows;
        int exp_sk;
        logic [K_W-1:0] r;
        clear_mon();
        exp_sk = v.err ? 0 : v.kl;
        exp_rows = v.err ? model_rows : v.kl;
        for (int i = 0; i < exp_sk; i++) begin
            r = K_W'(v.kb + i);
            exp_q.push_back(r);
        end
        k_base = K_W'(v.kb);
        k_len = (K_W+1)'(v.kl);
        tile_start = 1'b1;
        st = cyc;
        tick();
        tile_start = 1'b0;
        wait_done(v.kl * 8 + 40, $sformatf("v%0d_finish", idx));
        repeat (3) tick();
        chk($sformatf("v%0d_err_pulses", idx), err_cnt, int'(v.err));
        chk($sformatf("v%0d_done_pulses", idx), done_cnt, int'(!v.err));
        chk($sformatf("v%0d_start_k", idx), sk_cnt, exp_sk);
        chk($sformatf("v%0d_accepts", idx), acc_cnt, exp_sk);
        chk($sformatf("v%0d_rows_done", idx), int'(rows_done), exp_rows);
        chk($sformatf("v%0d_ready", idx), int'(tile_ready), 1);
        chk($sformatf("v%0d_queue", idx), exp_q.size(), 0);
        if (v.err) begin
            chk($sformatf("v%0d_err_lat", idx), err_cyc - st, 1);
            chk($sformatf("v%0d_busy", idx), busy_cnt, 0);
        end else if (v.kl == 0) begin
            chk($sformatf("v%0d_done_lat", idx), done_cyc - st, 1);
            chk($sformatf("v%0d_busy", idx), busy_cnt, 0);
        end else begin
            chk($sformatf("v%0d_first_lat", idx), sk_cyc - st, 2);
        end
        model_rows = exp_rows;
    endtask

    initial begin
        int st;
        int n;
        ld.row_valid = 1'b0;
        vecs[0] = '{kb: 4,    kl: 3,    err: 1'b0};
        vecs[1] = '{kb: 1020, kl: 5,    err: 1'b1};
        vecs[2] = '{kb: 0,    kl: 0,    err: 1'b0};
        vecs[3] = '{kb: 1020, kl: 4,    err: 1'b0};
        vecs[4] = '{kb: 1023, kl: 2,    err: 1'b1};
        vecs[5] = '{kb: 0,    kl: 1024, err: 1'b0};

        clear_mon();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", int'(tile_ready), 1);
        chk("rst_busy", int'(tile_busy), 0);
        chk("rst_rows", int'(rows_done), 0);
        chk("rst_start_k", int'(ld.start_k), 0);
        chk("rst_k_idx", int'(ld.k_idx), 0);
        chk("rst_done", int'(tile_done), 0);
        cpu_x_req = 1'b1;
        #1;
        chk("rst_gnt_req", int'(cpu_x_gnt), 1);
        cpu_x_req = 1'b0;
        #1;
        chk("rst_gnt_idle", int'(cpu_x_gnt), 0);
        rst_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // CPU holds the write port for five ISSUE cycles.
        clear_mon();
        exp_q.push_back(K_W'(10));
        k_base = K_W'(10);
        k_len = (K_W+1)'(1);
        tile_start = 1'b1;
        st = cyc;
        tick();
        tile_start = 1'b0;
        cpu_x_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("cpu_gnt_issue%0d", i), int'(cpu_x_gnt), 1);
            chk($sformatf("cpu_no_start%0d", i), int'(ld.start_k), 0);
            tick();
        end
        cpu_x_req = 1'b0;
        tick();
        cpu_x_req = 1'b1;
        @(negedge clk);
        chk("cpu_start_k_late", int'(ld.start_k), 1);
        chk("cpu_start_delay", cyc - st, 7);
        chk("cpu_gnt_wait_row", int'(cpu_x_gnt), 0);
        tick();
        cpu_x_req = 1'b0;
        wait_done(40, "cpu_finish");
        repeat (2) tick();
        chk("cpu_done", done_cnt, 1);
        chk("cpu_accepts", acc_cnt, 1);
        chk("cpu_rows", int'(rows_done), 1);

        // Abort while waiting on the second row; loader answers later.
        clear_mon();
        lat = 4;
        exp_q.push_back(K_W'(8));
        exp_q.push_back(K_W'(9));
        k_base = K_W'(8);
        k_len = (K_W+1)'(4);
        tile_start = 1'b1;
        tick();
        tile_start = 1'b0;
        n = 0;
        while (sk_cnt < 2 && n < 60) begin
            tick();
            n++;
        end
        chk("abort_reach_row2", int'(n < 60), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n = 0;
        while (!tile_ready && n < 40) begin
            tick();
            n++;
        end
        chk("abort_to_idle", int'(n < 40), 1);
        repeat (4) tick();
        chk("abort_accepts", acc_cnt, 2);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_rows", int'(rows_done), 1);
        chk("abort_row_valid", int'(ld.row_valid), 0);
        chk("abort_start_k", sk_cnt, 2);
        chk("abort_no_timeout", to_cnt, 0);
        lat = 2;

        // Reset mid-tile returns to reset values at once.
        clear_mon();
        for (int i = 0; i < 8; i++) exp_q.push_back(K_W'(i));
        k_base = '0;
        k_len = (K_W+1)'(8);
        tile_start = 1'b1;
        tick();
        tile_start = 1'b0;
        n = 0;
        while (sk_cnt < 3 && n < 60) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", int'(n < 60), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", int'(tile_ready), 1);
        chk("rst_mid_busy", int'(tile_busy), 0);
        chk("rst_mid_rows", int'(rows_done), 0);
        chk("rst_mid_k_idx", int'(ld.k_idx), 0);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) tick();
        chk("rst_mid_idle", int'(tile_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "bench time limit");
    end

endmodule
